// File: rtl/cut_bist_sequencer.sv
// BIST sequencer: resets one CUT, applies LFSR vectors, compacts its output into a MISR
// and registers a pass/fail verdict against a golden signature.
module cut_bist_sequencer #(
    parameter int         PAT_COUNT = 64,
    parameter int         LATENCY   = 4,
    parameter int         INIT_CYC  = 2,
    parameter logic [7:0] SEED      = 8'h01
) (
    input  logic        I1294_clk,
    input  logic        I1301_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] golden_sig,
    input  logic        cut_out,
    output logic [4:0]  cut_in,
    output logic        cut_rst_n,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);
    localparam logic [7:0]  SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0] INIT_LAST = 16'(INIT_CYC - 1);
    localparam logic [15:0] PAT_LAST  = 16'(PAT_COUNT - 1);
    localparam logic [15:0] LAT_LAST  = 16'(LATENCY - 1);
    localparam logic [16:0] PAT_W     = 17'(PAT_COUNT);
    localparam logic [16:0] LAT_W     = 17'(LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_APPLY,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [15:0] phase;
    logic [7:0]  lfsr, lfsr_next;
    logic [15:0] misr_next;
    logic        capture;

    always_ff @(posedge I1294_clk or negedge I1301_rst) begin
        if (!I1301_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture cycles are counted from the first APPLY cycle and are offset by the CUT latency
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        misr_next  = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000)
                     ^ {15'b0, cut_out};
        case (state)
            S_IDLE: begin
                if (start) state_next = S_INIT;
            end
            S_INIT: begin
                if (abort)                   state_next = S_IDLE;
                else if (phase == INIT_LAST) state_next = S_APPLY;
            end
            S_APPLY: begin
                capture = !abort && (({1'b0, phase} + 17'd1) > LAT_W);
                if (abort)                  state_next = S_IDLE;
                else if (phase == PAT_LAST) state_next = (LATENCY == 0) ? S_DONE : S_FLUSH;
            end
            S_FLUSH: begin
                capture = !abort && (({1'b0, phase} + PAT_W + 17'd1) > LAT_W);
                if (abort)                  state_next = S_IDLE;
                else if (phase == LAT_LAST) state_next = S_DONE;
            end
            S_DONE: begin
                if (start) state_next = S_INIT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge I1294_clk or negedge I1301_rst) begin
        if (!I1301_rst) begin
            phase     <= 16'd0;
            lfsr      <= SEED_EFF;
            cut_in    <= 5'd0;
            cut_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= 16'd0;
        end else begin
            if (state_next != state) phase <= 16'd0;
            else if (busy)           phase <= phase + 16'd1;

            if (state_next == S_INIT && state != S_INIT) begin
                lfsr      <= SEED_EFF;
                signature <= 16'd0;
                pass      <= 1'b0;
            end else begin
                if (state == S_APPLY && !abort) lfsr <= lfsr_next;
                if (capture) signature <= misr_next;
                if (state_next == S_DONE && state != S_DONE) pass <= (misr_next == golden_sig);
            end

            // The register shows the vector for the coming cycle, so later vectors come from lfsr_next
            if (state_next == S_APPLY) cut_in <= (state == S_APPLY) ? lfsr_next[4:0] : lfsr[4:0];
            else                       cut_in <= 5'd0;

            cut_rst_n <= (state_next != S_INIT);
            busy      <= (state_next == S_INIT) || (state_next == S_APPLY) || (state_next == S_FLUSH);
            done      <= (state_next == S_DONE);
        end
    end
endmodule

// File: doc/cut_bist_sequencer.md
# cut_bist_sequencer

Built-in self-test sequencer for one registered circuit-under-test (CUT) subcircuit: it resets the CUT, applies a programmable number of pseudo-random 5-bit input vectors from an LFSR, and compacts the CUT's 1-bit output into a 16-bit MISR signature. At the end of the run the signature is compared against a golden value and a pass/fail verdict is reported. It sits between the test harness and each benchmark subcircuit, so that trojan-induced deviations show up as signature mismatches.

## Interface
- PAT_COUNT, 64: number of vectors applied per run (1..65535).
- LATENCY, 4: register depth from CUT input to CUT output, in cycles (0..255).
- INIT_CYC, 2: cycles the CUT reset is held low before vectors start (1..255).
- SEED, 8'h01: LFSR load value. A value of 0 is replaced by 8'h01.
- I1294_clk  in  1  clock, rising edge.
- I1301_rst  in  1  reset; asynchronous and active-low. Applies to every register in the block.
- start  in  1  begins a run; sampled in IDLE and DONE only.
- abort  in  1  cancels a run in progress.
- golden_sig  in  16  expected signature; sampled on the edge that enters DONE.
- cut_out  in  1  CUT output.
- cut_in  out  5  vector driven to the CUT.
- cut_rst_n  out  1  active-low reset to the CUT.
- busy  out  1  high in INIT, APPLY and FLUSH.
- done  out  1  high in DONE.
- pass  out  1  verdict; valid while done is high.
- signature  out  16  MISR contents.

## Operation
- FSM states: IDLE, INIT, APPLY, FLUSH, DONE.
- IDLE: start=1 moves the FSM to INIT.
- INIT: lasts INIT_CYC cycles. Then the FSM moves to APPLY.
- APPLY: lasts PAT_COUNT cycles. Then the FSM moves to FLUSH, or to DONE if LATENCY=0.
- FLUSH: lasts LATENCY cycles. Then the FSM moves to DONE.
- DONE: outputs are held. start=1 moves the FSM to INIT, which begins a new run.
- abort=1 in INIT, APPLY or FLUSH returns the FSM to IDLE on the next edge. done is not asserted and signature keeps its partial value.
- Priority: abort beats start. start is ignored in INIT, APPLY and FLUSH.
- LFSR (8-bit, Fibonacci, x^8+x^6+x^5+x^4+1):
  - Update: next = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
  - Loaded with SEED on entry to INIT; advances once per APPLY cycle.
  - cut_in = q[4:0] during APPLY, otherwise 0.
- MISR (16-bit, polynomial 0x1021):
  - Update: next = {s[14:0],1'b0} ^ (s[15] ? 16'h1021 : 0) ^ {15'b0, cut_out}.
  - Cleared on entry to INIT.
  - Updates only in capture cycles, which are the cycles numbered LATENCY .. LATENCY+PAT_COUNT-1 counted from the first APPLY cycle. This gives exactly PAT_COUNT samples.
- pass is registered as (MISR next value == golden_sig) on the edge that enters DONE. pass is cleared on entry to INIT.
- Counters: one 16-bit phase counter, reloaded at each state entry. No wrap occurs within the parameter ranges above.

## Timing
- Reset values: IDLE, cut_in=0, cut_rst_n=0, busy=0, done=0, pass=0, signature=0, LFSR=SEED.
- After reset deasserts, cut_rst_n is 1 in IDLE. It is 0 only in INIT and during reset.
- Run timing:
  - start is sampled at edge E0.
  - INIT occupies E0..E0+INIT_CYC.
  - The first vector (LFSR = SEED) is on cut_in after edge E0+INIT_CYC.
  - done rises at edge E0+INIT_CYC+PAT_COUNT+LATENCY. With defaults that is 70 cycles.
- All outputs are registered. There is no combinational path from input to output.
- Asserting I1301_rst mid-run immediately forces the reset values. No run resumes after reset.

## Test plan
- SEED=8'h01, PAT_COUNT=5, LATENCY=0 -> cut_in over successive APPLY cycles is 01,02,04,08,11. cut_in is 0 outside APPLY.
- cut_out tied 0, golden_sig=0, defaults -> done rises at the 70th edge after the start sample, pass=1, signature=0000.
- cut_out tied 1, PAT_COUNT=2, LATENCY=1, golden_sig=16'h0003 -> signature=0003 and pass=1. Repeat with golden_sig=16'h0004 -> pass=0.
- Assert abort during APPLY -> IDLE on the next edge, busy=0, done stays 0. A following start gives a full run with identical results.
- Drive I1301_rst low during FLUSH -> all outputs go to reset values asynchronously (cut_rst_n=0, signature=0) before the next clock edge.
- In DONE, pulse start together with abort -> new run enters INIT (abort has no effect outside busy states). pass clears and cut_rst_n is low for 2 cycles.
